// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles, LSB first,
// with a start/busy/done handshake and registered sum, carry-out and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;
  logic             sum_bit;
  logic             carry_nxt;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  assign sum_bit   = fa_sum(sa[0], sb[0], c);
  assign carry_nxt = fa_carry(sa[0], sb[0], c);
  assign last      = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // A start in the completion cycle chains straight into the next operation.
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= sub ? ~b : b;
      c   <= sub ? 1'b1 : cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {sum_bit, sr[WIDTH-1:1]};
      c   <= carry_nxt;
      cnt <= cnt + CNT_W'(1);
      // On the MSB step, c still holds the carry into the MSB.
      if (last) begin
        s    <= {sum_bit, sr[WIDTH-1:1]};
        cout <= carry_nxt;
        ovf  <= c ^ carry_nxt;
      end
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor, WIDTH bits.
- Reuses a single full-adder cell over WIDTH cycles, LSB first.
- Carry is held in a flip-flop between cycles.
- Sits beside the combinational adder blocks as the area-minimal, multi-cycle option, with a start/busy/done handshake and signed overflow plus subtract modes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block is not busy.
- sub  input  1  operation mode, sampled with start. 0: a+b+cin. 1: a-b, computed as a+~b+1; cin is ignored.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry in, sampled with start; used only when sub=0.
- s  output  WIDTH  registered result.
- cout  output  1  registered carry out of the MSB; for sub=1, 1 means no borrow.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; s, cout and ovf are valid from this cycle onward.

Behaviour:
- Reset: while reset is high at a clock edge, the state goes to IDLE and all internal registers clear. Outputs reset values: s=0, cout=0, ovf=0, busy=0, done=0. Reset has priority over everything, including mid-operation.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch a into shift register SA;
  - latch b (or ~b when sub=1) into shift register SB;
  - load carry flip-flop C with cin (or 1 when sub=1);
  - clear bit counter;
  - go to RUN; busy=1 from E0.
- IDLE, start=0: stay in IDLE.
- RUN, at each edge Ek for k=1..WIDTH:
  - compute sum bit = SA[0]^SB[0]^C and next carry = majority(SA[0],SB[0],C);
  - shift the sum bit into internal register SR from the MSB end;
  - shift SA and SB right; update C;
  - increment the counter.
  - At the edge processing bit WIDTH-1, also capture the carry into the MSB (the C value before the update) for ovf.
- RUN to DONE at edge E_WIDTH. At that edge:
  - s <= final SR;
  - cout <= final C;
  - ovf <= carry-into-MSB XOR final C;
  - busy <= 0; done <= 1.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH+1 edges after start was sampled.
- DONE lasts exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back ops; done and the new busy coincide for one cycle).
  - Otherwise DONE returns to IDLE.
- s, cout and ovf are stable while busy. They change only at the completing edge and hold until the next completion or reset. Intermediate bits are never visible on s.
- start while in RUN is ignored; operand and sub changes during RUN have no effect.
- Counter width is clog2(WIDTH+1). The counter does not wrap during an operation.
- Reset mid-RUN aborts the operation: no done pulse, and outputs go to reset values.

Test Plan (WIDTH=8):
- Reset: hold reset for 2 cycles → s=8'h00, cout=0, ovf=0, busy=0, done=0.
- Basic add: a=8'h0F, b=8'h01, cin=0, sub=0, start pulse.
  - busy=1 for 8 cycles; done pulses exactly 9 edges after start.
  - s=8'h10, cout=0, ovf=0.
- Carry chain: a=8'hFF, b=8'h01, cin=1 → s=8'h01, cout=1, ovf=0.
- Signed overflow: a=8'h7F, b=8'h01, cin=0 → s=8'h80, cout=0, ovf=1.
- Subtract: sub=1, a=8'h05, b=8'h07, cin=1 (ignored) → s=8'hFE, cout=0, ovf=0.
  - Then sub=1, a=8'h80, b=8'h01 → s=8'h7F, cout=1, ovf=1.
- Handshake and abort:
  - Change a and b and pulse start during RUN → result still equals the original operands.
  - Start asserted in the DONE cycle → second result is correct after another 9 edges.
  - Reset asserted 3 cycles into RUN → busy=0, s=0, and no done pulse.
